pipeline_hazard_ctrl: RTL and testbench

//  Sequences the 5-stage pipeline: generates PC/IF-ID write enables, IF-ID flush and
//  ID-EX bubble for load-use, ecall-operand and EX-resolved control hazards; holds the

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 15 +
 rtl/pipeline_hazard_ctrl_hazard_detect.sv | 31 +++
 rtl/pipeline_hazard_ctrl.sv | 145 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard / sequencing controller.
// Holds the FSM encoding and the ecall register conventions.
package pipeline_hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      S_RUN,
      S_MEM_WAIT,
      S_DRAIN,
      S_HALTED
   } state_t;

   localparam logic [4:0] ECALL_ARG_REG = 5'd17;
   localparam int         HALT_CODE     = 10;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Pure combinational load-use and ecall-operand dependency detection.
// x0 is never a real producer, so loads to x0 never stall.
module pipeline_hazard_ctrl_hazard_detect
   import pipeline_hazard_ctrl_pkg::*;
(
   input  logic       i_id_use_rs1,
   input  logic       i_id_use_rs2,
   input  logic [4:0] i_id_rs1,
   input  logic [4:0] i_id_rs2,
   input  logic       i_id_is_ecall,
   input  logic       i_ex_mem_read,
   input  logic       i_ex_reg_write,
   input  logic [4:0] i_ex_rd,
   output logic       o_load_use,
   output logic       o_ecall_dep
);

   logic w_hit_rs1;
   logic w_hit_rs2;

   assign w_hit_rs1 = i_id_use_rs1 & (i_ex_rd == i_id_rs1);
   assign w_hit_rs2 = i_id_use_rs2 & (i_ex_rd == i_id_rs2);

   assign o_load_use = i_ex_mem_read & (i_ex_rd != 5'd0)
                     & (w_hit_rs1 | w_hit_rs2);

   // A value in MEM is forwarded, so only an EX producer of x17 blocks.
   assign o_ecall_dep = i_id_is_ecall & i_ex_reg_write
                      & (i_ex_rd == ECALL_ARG_REG);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// 5-stage pipeline sequencer: stalls, flushes, memory holds,
// ecall drain/halt and saturating stall/flush performance counters.
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int DRAIN_CYCLES = 3,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic             id_is_ecall,
   input  logic             id_x17_is_ten,
   input  logic             ex_mem_read,
   input  logic             ex_reg_write,
   input  logic [4:0]       ex_rd,
   input  logic             ex_mispredict,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             id_ex_bubble,
   output logic             pipe_hold,
   output logic             is_halted,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
   localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

   state_t           r_state;
   state_t           w_next;
   logic [DW-1:0]    r_drain;
   logic [DW-1:0]    w_next_drain;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   logic w_load_use;
   logic w_ecall_dep;
   logic w_mem_wait;
   logic w_stuck;
   logic w_mp_flush;

   pipeline_hazard_ctrl_hazard_detect u_hazard (
      .i_id_use_rs1   (id_use_rs1),
      .i_id_use_rs2   (id_use_rs2),
      .i_id_rs1       (id_rs1),
      .i_id_rs2       (id_rs2),
      .i_id_is_ecall  (id_is_ecall),
      .i_ex_mem_read  (ex_mem_read),
      .i_ex_reg_write (ex_reg_write),
      .i_ex_rd        (ex_rd),
      .o_load_use     (w_load_use),
      .o_ecall_dep    (w_ecall_dep)
   );

   assign w_mem_wait = mem_req & ~mem_ready;
   // Once waiting, only mem_ready releases the hold.
   assign w_stuck = (r_state == S_MEM_WAIT) ? ~mem_ready : w_mem_wait;

   always_comb begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      pipe_hold    = 1'b0;
      w_mp_flush   = 1'b0;
      w_next       = r_state;
      w_next_drain = r_drain;
      unique case (r_state)
         S_RUN, S_MEM_WAIT: begin
            if (w_stuck) begin
               pc_write    = 1'b0;
               if_id_write = 1'b0;
               pipe_hold   = 1'b1;
               w_next      = S_MEM_WAIT;
            end else begin
               w_next = S_RUN;
               if (ex_mispredict) begin
                  if_id_flush  = 1'b1;
                  id_ex_bubble = 1'b1;
                  w_mp_flush   = 1'b1;
               end else if (w_load_use | w_ecall_dep) begin
                  pc_write     = 1'b0;
                  if_id_write  = 1'b0;
                  id_ex_bubble = 1'b1;
               end else if (id_is_ecall & id_x17_is_ten) begin
                  pc_write     = 1'b0;
                  if_id_flush  = 1'b1;
                  w_next       = (DRAIN_CYCLES > 1) ? S_DRAIN : S_HALTED;
                  w_next_drain = DRAIN_LOAD;
               end
            end
         end
         S_DRAIN: begin
            pc_write    = 1'b0;
            if_id_flush = 1'b1;
            pipe_hold   = w_mem_wait;
            if_id_write = ~w_mem_wait;
            if (!w_mem_wait) begin
               if (r_drain <= DW'(1)) w_next = S_HALTED;
               else w_next_drain = r_drain - DW'(1);
            end
         end
         S_HALTED: begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            pipe_hold   = 1'b1;
         end
         default: w_next = S_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_RUN;
         r_drain <= '0;
      end else begin
         r_state <= w_next;
         r_drain <= w_next_drain;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (!pc_write && r_state != S_HALTED && r_stall_cnt != '1)
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if (w_mp_flush && r_flush_cnt != '1)
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
   end

   assign is_halted = (r_state == S_HALTED);
   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed + random bench for pipeline_hazard_ctrl against a cycle
// model built from the hazard/drain rules; a 4-bit copy checks saturation.
module tb_pipeline_hazard_ctrl;

   localparam int DRAIN = 3;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
   logic       id_use_rs1 = 0, id_use_rs2 = 0, id_is_ecall = 0;
   logic       id_x17_is_ten = 0, ex_mem_read = 0, ex_reg_write = 0;
   logic       ex_mispredict = 0, mem_req = 0, mem_ready = 0;

   logic        pc_write, if_id_write, if_id_flush, id_ex_bubble;
   logic        pipe_hold, is_halted;
   logic [31:0] stall_cnt, flush_cnt;
   logic        s_pc, s_ifw, s_fl, s_bub, s_hold, s_halt;
   logic [3:0]  s_stall, s_flush;

   int total = 0;
   int bad   = 0;

   // model state
   bit     m_halted, m_wait;
   int     m_left;
   longint m_stall, m_flush;
   bit     n_halted, n_wait;
   int     n_left;
   longint n_stall, n_flush;
   bit     e_pc, e_ifw, e_fl, e_bub, e_hold;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(32)) dut (
      .clk(clk), .reset_n(reset_n),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .id_is_ecall(id_is_ecall), .id_x17_is_ten(id_x17_is_ten),
      .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
      .ex_rd(ex_rd), .ex_mispredict(ex_mispredict),
      .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_write(pc_write), .if_id_write(if_id_write),
      .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
      .pipe_hold(pipe_hold), .is_halted(is_halted),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   pipeline_hazard_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(4)) dut_sat (
      .clk(clk), .reset_n(reset_n),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .id_is_ecall(id_is_ecall), .id_x17_is_ten(id_x17_is_ten),
      .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
      .ex_rd(ex_rd), .ex_mispredict(ex_mispredict),
      .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_write(s_pc), .if_id_write(s_ifw),
      .if_id_flush(s_fl), .id_ex_bubble(s_bub),
      .pipe_hold(s_hold), .is_halted(s_halt),
      .stall_cnt(s_stall), .flush_cnt(s_flush)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_halted = 0; m_wait = 0; m_left = 0; m_stall = 0; m_flush = 0;
   endtask

   task automatic model_eval();
      bit lu, ed, held;
      lu = ex_mem_read && ex_rd != 0 &&
           ((id_use_rs1 && ex_rd == id_rs1) || (id_use_rs2 && ex_rd == id_rs2));
      ed = id_is_ecall && ex_reg_write && ex_rd == 17;
      e_pc = 1; e_ifw = 1; e_fl = 0; e_bub = 0; e_hold = 0;
      n_halted = m_halted; n_wait = m_wait; n_left = m_left;
      n_stall = m_stall; n_flush = m_flush;
      if (m_halted) begin
         e_pc = 0; e_ifw = 0; e_hold = 1;
      end else if (m_left > 0) begin
         held = mem_req && !mem_ready;
         e_pc = 0; e_fl = 1; e_hold = held; e_ifw = !held;
         if (!held) begin
            n_left = m_left - 1;
            if (n_left == 0) n_halted = 1;
         end
      end else begin
         held = m_wait ? !mem_ready : (mem_req && !mem_ready);
         n_wait = held;
         if (held) begin
            e_pc = 0; e_ifw = 0; e_hold = 1;
         end else if (ex_mispredict) begin
            e_fl = 1; e_bub = 1; n_flush = m_flush + 1;
         end else if (lu || ed) begin
            e_pc = 0; e_ifw = 0; e_bub = 1;
         end else if (id_is_ecall && id_x17_is_ten) begin
            e_pc = 0; e_fl = 1; n_left = DRAIN - 1;
         end
      end
      if (!m_halted && !e_pc) n_stall = m_stall + 1;
   endtask

   task automatic compare_all(input string ph);
      model_eval();
      chk({ph, ".pc_write"},     32'(pc_write),     32'(e_pc));
      chk({ph, ".if_id_write"},  32'(if_id_write),  32'(e_ifw));
      chk({ph, ".if_id_flush"},  32'(if_id_flush),  32'(e_fl));
      chk({ph, ".id_ex_bubble"}, 32'(id_ex_bubble), 32'(e_bub));
      chk({ph, ".pipe_hold"},    32'(pipe_hold),    32'(e_hold));
      chk({ph, ".is_halted"},    32'(is_halted),    32'(m_halted));
      chk({ph, ".stall_cnt"},    stall_cnt,         32'(m_stall));
      chk({ph, ".flush_cnt"},    flush_cnt,         32'(m_flush));
      chk({ph, ".sat_stall"},    32'(s_stall),
          32'((m_stall > 15) ? 15 : m_stall));
      chk({ph, ".sat_flush"},    32'(s_flush),
          32'((m_flush > 15) ? 15 : m_flush));
   endtask

   // called at a negedge with inputs driven; returns at the next negedge
   task automatic step(input string ph);
      #1;
      compare_all(ph);
      m_halted = n_halted; m_wait = n_wait; m_left = n_left;
      m_stall = n_stall; m_flush = n_flush;
      @(negedge clk);
   endtask

   task automatic idle();
      id_rs1 = 0; id_rs2 = 0; ex_rd = 0; id_use_rs1 = 0; id_use_rs2 = 0;
      id_is_ecall = 0; id_x17_is_ten = 0; ex_mem_read = 0;
      ex_reg_write = 0; ex_mispredict = 0; mem_req = 0; mem_ready = 0;
   endtask

   task automatic do_reset();
      idle();
      #2 reset_n = 0;
      #1 model_reset();
      compare_all("reset");
      @(negedge clk);
      reset_n = 1;
   endtask

   initial begin
      @(negedge clk);
      do_reset();

      // load-use on rs2: one stall cycle
      ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5;
      id_rs1 = 1; id_rs2 = 5; id_use_rs1 = 1; id_use_rs2 = 1;
      step("lu");
      idle(); step("lu_after");

      // load to x0, and rs1 match that is not actually read
      ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
      step("lu_x0");
      ex_rd = 7; id_rs1 = 7; id_use_rs1 = 0;
      step("lu_unused");
      idle();

      // mispredict overrides load-use
      ex_mem_read = 1; ex_rd = 3; id_rs1 = 3; id_use_rs1 = 1;
      ex_mispredict = 1;
      step("mp_lu");
      idle();

      // 4-cycle memory hold, mispredict ignored until release
      mem_req = 1;
      for (int i = 0; i < 4; i++) begin
         ex_mispredict = (i >= 2);
         step("memwait");
      end
      mem_ready = 1; ex_mispredict = 1;
      step("mem_release");
      idle(); step("mem_after");

      // ecall blocked by x17 producer in EX, then drains and halts
      id_is_ecall = 1; ex_reg_write = 1; ex_rd = 17;
      step("ecall_dep");
      ex_reg_write = 0; ex_rd = 0; id_x17_is_ten = 1;
      step("ecall_go");
      idle();
      for (int i = 0; i < 6; i++) step("drain_halt");

      // reset mid-drain
      do_reset();
      id_is_ecall = 1; id_x17_is_ten = 1;
      step("ecall_go2");
      idle(); step("drain2");
      do_reset();
      step("after_rst");

      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         id_rs1        = 5'($urandom_range(0, 7));
         id_rs2        = 5'($urandom_range(0, 7));
         id_use_rs1    = 1'($urandom);
         id_use_rs2    = 1'($urandom);
         ex_rd         = ($urandom % 5 == 0) ? 5'd17 : 5'($urandom_range(0, 7));
         ex_mem_read   = ($urandom % 3 == 0);
         ex_reg_write  = 1'($urandom);
         ex_mispredict = ($urandom % 7 == 0);
         id_is_ecall   = ($urandom % 12 == 0);
         id_x17_is_ten = 1'($urandom);
         mem_req       = ($urandom % 3 == 0);
         mem_ready     = ($urandom % 5 < 3);
         if (m_halted && ($urandom % 4 == 0)) do_reset();
         else step("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
